// File: rtl/vga_rx_pkg.sv
// rtl/vga_rx_pkg.sv - shared state enum, pixel type and default 640x480 timing for the VGA receive monitor
package vga_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  typedef logic [11:0] rgb12_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Position counters saturate here when a sync never arrives
  localparam logic [9:0] CNT_MAX = 10'h3FF;

endpackage

// File: rtl/vga_rx_axis_tracker.sv
// rtl/vga_rx_axis_tracker.sv - one timing axis: sync edge detect, position counter, edge checks, active window
module vga_rx_axis_tracker
  import vga_rx_pkg::*;
#(
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int ACTIVE = 640,
  parameter int TOTAL  = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_i,
  input  logic       sync_i,
  output logic       start_o,
  output logic       err_o,
  output logic       active_o,
  output logic [9:0] coord_o
);

  localparam logic [9:0]  SYNC_C   = 10'(SYNC);
  localparam logic [9:0]  OFFSET_C = 10'(SYNC + BP);
  localparam logic [9:0]  ACTIVE_C = 10'(ACTIVE);
  localparam logic [10:0] TOTAL_C  = 11'(TOTAL);

  logic       sync_prev_q, sync_prev_d;
  logic [9:0] cnt_q, cnt_d, offset;
  logic       start, fall;

  // Edge detect, counter advance and the per-step timing checks.
  // cnt_d is the position of the current sample when stepping, else the held one.
  always_comb begin
    start       = step_i & sync_i & ~sync_prev_q;
    fall        = step_i & ~sync_i & sync_prev_q;
    sync_prev_d = step_i ? sync_i : sync_prev_q;
    cnt_d       = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (step_i && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 10'd1;
    end
    err_o = 1'b0;
    if (start) begin
      // sync must restart exactly one period after the previous start
      err_o = (({1'b0, cnt_q} + 11'd1) != TOTAL_C);
    end else if (step_i) begin
      if ({1'b0, cnt_d} == TOTAL_C)   err_o = 1'b1;  // expected restart missing
      if (fall && cnt_d != SYNC_C)    err_o = 1'b1;  // sync pulse too short or too long
      if (sync_i && cnt_d == SYNC_C)  err_o = 1'b1;  // sync still held at its end point
      if (cnt_q == CNT_MAX - 10'd1)   err_o = 1'b1;  // counter just hit saturation
    end
    offset   = cnt_d - OFFSET_C;
    active_o = (cnt_d >= OFFSET_C) && (offset < ACTIVE_C);
  end

  assign start_o = start;
  assign coord_o = offset;

  // Counter and previous-sync registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sync_prev_q <= sync_prev_d;
    end
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive checker: coordinate recovery, timing lock, errors; VGA_RX_SUM_EN adds the frame checksum
module vga_rx_monitor
  import vga_rx_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_button,
  input  logic        pix_en,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        timing_err,
  output logic [7:0]  err_count
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  rgb12_t     rgb_in;
  logic       hs_on, vs_on;
  logic       h_start, h_err, h_act, v_start, v_err, v_act;
  logic [9:0] h_coord, v_coord;
  logic       tracking, err_now, frame_tick, pix_hit;

  rx_state_e  state_q, state_d;
  logic       locked_q, locked_d, valid_q, valid_d, done_q, done_d, terr_q, terr_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  rgb12_t     rgb_q, rgb_d;
  logic [7:0] errcnt_q, errcnt_d;

  assign rgb_in = {red, green, blue};
  assign hs_on  = (vga_hsync == SYNC_ACT);
  assign vs_on  = (vga_vsync == SYNC_ACT);

  vga_rx_axis_tracker #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .TOTAL(H_TOTAL)
  ) u_h_axis (
    .clk(clk), .rst_n(reset_button), .step_i(pix_en), .sync_i(hs_on),
    .start_o(h_start), .err_o(h_err), .active_o(h_act), .coord_o(h_coord)
  );

  // Vertical axis advances once per line, on each hsync tick
  vga_rx_axis_tracker #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .TOTAL(V_TOTAL)
  ) u_v_axis (
    .clk(clk), .rst_n(reset_button), .step_i(h_start), .sync_i(vs_on),
    .start_o(v_start), .err_o(v_err), .active_o(v_act), .coord_o(v_coord)
  );

  // Checks are only meaningful once aligned to a frame start
  assign tracking   = (state_q != ST_HUNT);
  assign err_now    = tracking & (h_err | v_err);
  assign frame_tick = tracking & v_start & ~err_now;
  assign pix_hit    = pix_en & h_act & v_act & tracking;

  // Next-state decode for the HUNT/ALIGN/LOCKED tracker
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:   if (v_start) state_d = ST_ALIGN;
      ST_ALIGN:  if (err_now) state_d = ST_HUNT;
                 else if (v_start) state_d = ST_LOCKED;
      ST_LOCKED: if (err_now) state_d = ST_HUNT;
      default:   state_d = ST_HUNT;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  // Pixel strobe, coordinate capture, pulses and saturating error counter
  always_comb begin
    valid_d = pix_hit;
    x_d     = x_q;
    y_d     = y_q;
    rgb_d   = rgb_q;
    if (pix_hit) begin
      x_d   = h_coord;
      y_d   = v_coord;
      rgb_d = rgb_in;
    end
    done_d   = frame_tick;
    terr_d   = err_now;
    errcnt_d = errcnt_q;
    if (err_now && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
  end

  // State and output registers; reset clears every output at once
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      state_q  <= ST_HUNT;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rgb_q    <= rgb_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      errcnt_q <= errcnt_d;
    end
  end

`ifdef VGA_RX_SUM_EN
  logic [15:0] acc_q, acc_d, sum_q, sum_d;

  // Frame accumulator: cleared on alignment, handed to frame_sum at each clean frame start
  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (!tracking) begin
      if (v_start) acc_d = '0;
    end else if (frame_tick) begin
      sum_d = acc_q;
      acc_d = '0;
    end else if (pix_hit) begin
      acc_d = acc_q + {4'b0000, rgb_in};
    end
  end

  // Checksum registers
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = 16'h0000;
`endif

  assign pixel_valid = valid_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign pixel_rgb   = rgb_q;
  assign locked      = locked_q;
  assign frame_done  = done_q;
  assign timing_err  = terr_q;
  assign err_count   = errcnt_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - directed bench for vga_rx_monitor on a reduced 8x6 raster
module tb_vga_rx_monitor;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HS + HB + HA + HF;  // 15
  localparam int VT = VS + VB + VA + VF;  // 11
  localparam int GAP = 4;                 // pix_en every 4th clock

`ifdef VGA_RX_SUM_EN
  localparam logic [15:0] EXP_PAT = 16'h0828;  // sum of 16*y+x over 8x6
  localparam logic [15:0] EXP_FFF = 16'hFFD0;  // 48*0xFFF mod 2^16
  localparam logic [15:0] EXP_001 = 16'h0030;  // 48*1
`else
  localparam logic [15:0] EXP_PAT = 16'h0000;
  localparam logic [15:0] EXP_FFF = 16'h0000;
  localparam logic [15:0] EXP_001 = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset_button = 1'b0;
  logic        pix_en = 1'b0;
  logic        vga_hsync = 1'b1;
  logic        vga_vsync = 1'b1;
  logic [3:0]  red = '0, green = '0, blue = '0;
  logic        pixel_valid, locked, frame_done, timing_err;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] pixel_rgb;
  logic [15:0] frame_sum;
  logic [7:0]  err_count;

  int checks = 0, failures = 0;
  int nvalid = 0, ndone = 0, nerr = 0, nstuck = 0, nbadpix = 0;
  logic [9:0]  first_x = '0, first_y = '0, last_x = '0, last_y = '0;
  logic [11:0] last_rgb = '0;
  logic [15:0] last_sum = '0;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT(1'b0)
  ) dut (
    .clk(clk), .reset_button(reset_button), .pix_en(pix_en),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
    .locked(locked), .frame_done(frame_done), .frame_sum(frame_sum),
    .timing_err(timing_err), .err_count(err_count)
  );

  task automatic tick(input logic hs, input logic vs, input logic [11:0] rgb, input int ex, input int ey);
    @(negedge clk);
    vga_hsync = hs;
    vga_vsync = vs;
    {red, green, blue} = rgb;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    if (pixel_valid) begin
      if (nvalid == 0) begin
        first_x = pixel_x;
        first_y = pixel_y;
      end
      nvalid++;
      last_x = pixel_x;
      last_y = pixel_y;
      last_rgb = pixel_rgb;
      if (pixel_x !== 10'(ex) || pixel_y !== 10'(ey) || pixel_rgb !== rgb) nbadpix++;
    end
    if (frame_done) begin
      ndone++;
      last_sum = frame_sum;
    end
    if (timing_err) nerr++;
    repeat (GAP - 1) begin
      @(negedge clk);
      if (pixel_valid || frame_done || timing_err) nstuck++;
    end
  endtask

  // mode 0: solid colour, mode 1: 16*y+x pattern; bad_line gets an hsync one pixel short
  task automatic send_frame(input int mode, input logic [11:0] col, input int bad_line,
                            input int vs_lines, input int nlines);
    int x, y, hw;
    logic act;
    logic [11:0] c;
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < HT; p++) begin
        x   = p - (HS + HB);
        y   = l - (VS + VB);
        act = (x >= 0 && x < HA && y >= 0 && y < VA);
        c   = !act ? 12'hABC : (mode == 0 ? col : 12'(y * 16 + x));
        hw  = (l == bad_line) ? HS - 1 : HS;
        tick((p < hw) ? 1'b0 : 1'b1, (l < vs_lines) ? 1'b0 : 1'b1, c, x, y);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0h exp=0", locked); end
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", pixel_valid); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", frame_done); end
    checks++; if (frame_sum !== 16'h0) begin failures++; $display("FAIL reset_sum got=%0h exp=0", frame_sum); end
    checks++; if (err_count !== 8'h0) begin failures++; $display("FAIL reset_errcnt got=%0h exp=0", err_count); end
    checks++; if (timing_err !== 1'b0) begin failures++; $display("FAIL reset_terr got=%0h exp=0", timing_err); end
    checks++; if (pixel_x !== 10'h0) begin failures++; $display("FAIL reset_x got=%0h exp=0", pixel_x); end
    reset_button = 1'b1;
  endtask

  task automatic test_ideal_lock();
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL align_locked got=%0h exp=0", locked); end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL align_done got=%0d exp=0", ndone); end
    checks++; if (nvalid !== 48) begin failures++; $display("FAIL align_nvalid got=%0d exp=48", nvalid); end
    checks++; if (nerr !== 0) begin failures++; $display("FAIL align_nerr got=%0d exp=0", nerr); end
    checks++; if (first_x !== 10'd0) begin failures++; $display("FAIL first_x got=%0d exp=0", first_x); end
    checks++; if (first_y !== 10'd0) begin failures++; $display("FAIL first_y got=%0d exp=0", first_y); end
    checks++; if (last_x !== 10'd7) begin failures++; $display("FAIL last_x got=%0d exp=7", last_x); end
    checks++; if (last_y !== 10'd5) begin failures++; $display("FAIL last_y got=%0d exp=5", last_y); end
    checks++; if (last_rgb !== 12'h057) begin failures++; $display("FAIL last_rgb got=%0h exp=57", last_rgb); end
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%0h exp=1", locked); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL lock_done got=%0d exp=1", ndone); end
    checks++; if (last_sum !== EXP_PAT) begin failures++; $display("FAIL lock_sum got=%0h exp=%0h", last_sum, EXP_PAT); end
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (ndone !== 2) begin failures++; $display("FAIL third_done got=%0d exp=2", ndone); end
    checks++; if (nvalid !== 144) begin failures++; $display("FAIL third_nvalid got=%0d exp=144", nvalid); end
    checks++; if (nbadpix !== 0) begin failures++; $display("FAIL pixel_coords got=%0d exp=0", nbadpix); end
    checks++; if (nstuck !== 0) begin failures++; $display("FAIL pulse_width got=%0d exp=0", nstuck); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL clean_errcnt got=%0d exp=0", err_count); end
  endtask

  task automatic test_checksum();
    send_frame(0, 12'hFFF, -1, VS, VT);
    send_frame(0, 12'h001, -1, VS, VT);
    checks++; if (last_sum !== EXP_FFF) begin failures++; $display("FAIL sum_fff got=%0h exp=%0h", last_sum, EXP_FFF); end
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (last_sum !== EXP_001) begin failures++; $display("FAIL sum_001 got=%0h exp=%0h", last_sum, EXP_001); end
    checks++; if (frame_sum !== EXP_001) begin failures++; $display("FAIL sum_hold got=%0h exp=%0h", frame_sum, EXP_001); end
    checks++; if (ndone !== 5) begin failures++; $display("FAIL sum_done got=%0d exp=5", ndone); end
  endtask

  task automatic test_hsync_narrow();
    send_frame(1, 12'h000, 6, VS, VT);
    checks++; if (nerr !== 1) begin failures++; $display("FAIL hs_nerr got=%0d exp=1", nerr); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL hs_errcnt got=%0d exp=1", err_count); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL hs_unlock got=%0h exp=0", locked); end
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL hs_realign got=%0h exp=0", locked); end
    checks++; if (ndone !== 6) begin failures++; $display("FAIL hs_nodone got=%0d exp=6", ndone); end
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL hs_relock got=%0h exp=1", locked); end
    checks++; if (ndone !== 7) begin failures++; $display("FAIL hs_done got=%0d exp=7", ndone); end
    checks++; if (last_sum !== EXP_PAT) begin failures++; $display("FAIL hs_sum got=%0h exp=%0h", last_sum, EXP_PAT); end
    checks++; if (nerr !== 1) begin failures++; $display("FAIL hs_nerr_after got=%0d exp=1", nerr); end
  endtask

  task automatic test_vsync_long();
    send_frame(1, 12'h000, -1, 3, VT);
    checks++; if (nerr !== 2) begin failures++; $display("FAIL vs_nerr got=%0d exp=2", nerr); end
    checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL vs_errcnt got=%0d exp=2", err_count); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL vs_unlock got=%0h exp=0", locked); end
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL vs_realign got=%0h exp=0", locked); end
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL vs_relock got=%0h exp=1", locked); end
    checks++; if (ndone !== 9) begin failures++; $display("FAIL vs_done got=%0d exp=9", ndone); end
    checks++; if (nstuck !== 0) begin failures++; $display("FAIL vs_pulse_width got=%0d exp=0", nstuck); end
  endtask

  task automatic test_reset_midline();
    send_frame(1, 12'h000, -1, VS, 5);
    for (int p = 0; p < 7; p++) tick(p < HS ? 1'b0 : 1'b1, 1'b1, (p >= HS + HB) ? 12'h011 : 12'hABC, p - (HS + HB), 1);
    @(posedge clk);
    #2;
    reset_button = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0h exp=0", locked); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_errcnt got=%0d exp=0", err_count); end
    checks++; if (frame_sum !== 16'h0) begin failures++; $display("FAIL rst_sum got=%0h exp=0", frame_sum); end
    checks++; if (pixel_y !== 10'd0) begin failures++; $display("FAIL rst_y got=%0d exp=0", pixel_y); end
    checks++; if (pixel_rgb !== 12'h0) begin failures++; $display("FAIL rst_rgb got=%0h exp=0", pixel_rgb); end
    checks++; if (pixel_x !== 10'd0) begin failures++; $display("FAIL rst_x got=%0d exp=0", pixel_x); end
    repeat (3) @(negedge clk);
    reset_button = 1'b1;
    nerr = 0;
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_align got=%0h exp=0", locked); end
    send_frame(1, 12'h000, -1, VS, VT);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rst_relock got=%0h exp=1", locked); end
    checks++; if (nerr !== 0) begin failures++; $display("FAIL rst_nerr got=%0d exp=0", nerr); end
    checks++; if (last_sum !== EXP_PAT) begin failures++; $display("FAIL rst_sum_after got=%0h exp=%0h", last_sum, EXP_PAT); end
  endtask

  initial begin
    test_reset();
    test_ideal_lock();
    test_checksum();
    test_hsync_narrow();
    test_vsync_long();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

Receive-side checker for the VGA output of `spriteTop`. It consumes `vga_hsync`, `vga_vsync` and the 12-bit RGB bus on the system clock, using a pixel-clock enable. It recovers pixel coordinates, verifies horizontal and vertical timing against parameters, reports lock and errors, and produces a per-frame pixel checksum. It sits in simulation and on-chip self-test next to `spriteTop`, on the same clock.

## Interface
Parameters:
- `H_ACTIVE` = 640: visible pixels per line
- `H_FP` = 16, `H_SYNC` = 96, `H_BP` = 48: horizontal porches and sync, in pixels
- `V_ACTIVE` = 480: visible lines per frame
- `V_FP` = 10, `V_SYNC` = 2, `V_BP` = 33: vertical porches and sync, in lines
- `SYNC_ACT` = 0: asserted level of both syncs

Ports:
- `clk` in 1: system clock
- `reset_button` in 1: **asynchronous, active-low reset**
- `pix_en` in 1: pixel tick; inputs are sampled only when high
- `vga_hsync`, `vga_vsync` in 1: syncs from the generator, same clock domain
- `red`, `green`, `blue` in 4 each: pixel colour
- `pixel_valid` out 1: registered active-region pixel strobe
- `pixel_x` out 10: column, 0..H_ACTIVE-1
- `pixel_y` out 10: row, 0..V_ACTIVE-1
- `pixel_rgb` out 12: `{red,green,blue}`
- `locked` out 1: timing verified over at least one full frame
- `frame_done` out 1: one-cycle pulse at the end of each tracked frame
- `frame_sum` out 16: checksum of the completed frame
- `timing_err` out 1: one-cycle pulse on any timing mismatch
- `err_count` out 8: saturating count of timing errors

## Operation
- Derived constants:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800)
  - V_TOTAL likewise (525)
- Hsync tick: a `pix_en` cycle where sampled hsync is asserted and the previous sample was not. That tick defines `h_cnt` = 0. `h_cnt` increments on every `pix_en`.
- Vertical tracking happens only at hsync ticks. At each one, `vsync` is sampled, `v_cnt` increments, and a line with vsync asserted after one without defines `v_cnt` = 0.
- Active region:
  - x = h_cnt-(H_SYNC+H_BP), valid for x < H_ACTIVE
  - y = v_cnt-(V_SYNC+V_BP), valid for y < V_ACTIVE
- Horizontal checks:
  - hsync must deassert exactly at h_cnt = H_SYNC.
  - The next hsync tick must occur exactly at h_cnt = H_TOTAL.
- Vertical checks:
  - vsync must deassert exactly at v_cnt = V_SYNC.
  - vsync must reassert exactly at v_cnt = V_TOTAL.
- Any check failure:
  - pulse `timing_err`
  - increment `err_count`, saturating at 255
  - go to HUNT
- States:
  - HUNT → ALIGN on a vsync-start hsync tick; clears counters and the sum.
  - ALIGN → LOCKED at the next vsync-start tick if no error occurred.
  - LOCKED stays locked while checks pass.
  - ALIGN or LOCKED → HUNT on error.
- `pixel_valid` is driven only in ALIGN and LOCKED. `locked` = 1 only in LOCKED.
- Checksum: `frame_sum` accumulates the 12-bit pixel value, zero-extended, mod 2^16, over every valid pixel.
- At each vsync-start tick in ALIGN or LOCKED:
  - latch the sum into `frame_sum`
  - pulse `frame_done`
  - clear the accumulator
- A vsync-start tick that also fails a check does not pulse `frame_done`.

## Timing
- All outputs are registered. Coordinates, RGB and `pixel_valid` appear in the cycle after the sampling `pix_en` cycle.
- `frame_done`, `timing_err` and the `frame_sum` update also occur one cycle after the deciding tick.
- Reset values: every output is 0 and the state is HUNT. Reset takes effect immediately and mid-frame. After release, the block starts again from HUNT.
- `pix_en` low freezes all counters and state. Non-tick cycles never change outputs, except that pulses drop after one cycle.
- An hsync tick coinciding with an error:
  - the error is reported
  - the counters still restart at 0 for that line
- Counters are 10 bits for `h_cnt` and `v_cnt`. Saturate at 1023 if sync never arrives; the overrun is flagged as an error once.

## Configuration
- `VGA_RX_SUM_EN` defined: checksum accumulator present; `frame_sum` behaves as above.
- `VGA_RX_SUM_EN` not defined: no accumulator; `frame_sum` is tied to 0. `frame_done` still pulses.

## Structure
- Shared package `vga_rx_pkg` holds:
  - state enum (HUNT/ALIGN/LOCKED)
  - default 640x480 timing constants
  - the `rgb12_t` typedef
- Sub-module `vga_rx_axis_tracker`: parameterised by SYNC, BP, ACTIVE and TOTAL. It holds the counter, the edge checks, the active flag and the offset coordinate. It is instantiated twice: horizontally on `pix_en`, and vertically on hsync ticks.

## Test plan
- Ideal 640x480 stream with `pix_en` every 4th clock, 3 frames → `locked` = 1 after the second vsync tick; `frame_done` pulses once per frame; 307200 `pixel_valid` strobes per frame.
- Solid colour 0xFFF → `frame_sum` = 0x5000. Solid 0x001 → 0xB000. With `VGA_RX_SUM_EN` undefined → 0x0000.
- Corner pixels: first valid strobe has x=0, y=0; last has x=639, y=479 with the expected RGB.
- One line with hsync 95 pixels wide → `timing_err` pulse; `err_count` = 1; `locked` drops and returns after two further clean vsync ticks.
- vsync held asserted for 3 lines → error, HUNT, then relock.
- `reset_button` low mid-line in LOCKED → all outputs 0 immediately; relock after release.
